// File: rtl/rs_syndrome.sv
// rs_syndrome -- Reed-Solomon syndrome generator, 16 syndromes over GF(2^8)
//
// Computes S_i = r(alpha^i), i = 0..15, with p(x) = x^8+x^4+x^3+x^2+1 and
// alpha = 0x02. Symbols arrive highest-degree first, one per accepted cycle.
// The code length is N symbols, which allows shortened codes.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   din_valid  din carries a received symbol this cycle
//   din_sop    first symbol of a codeword (qualified by din_valid)
//   din        received symbol
//   synd_valid one-cycle pulse when synd holds a new result
//   synd       S0 in [7:0] .. S15 in [127:120], held until the next pulse
//   err_flag   any syndrome non-zero (only when RS_ERR_FLAG_EN is defined)
//
// Optional feature macro: RS_ERR_FLAG_EN
module rs_syndrome #(
    parameter int unsigned N = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din_valid,
    input  logic         din_sop,
    input  logic [7:0]   din,
    output logic         synd_valid,
    output logic [127:0] synd
`ifdef RS_ERR_FLAG_EN
    ,
    output logic         err_flag
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // cnt_q holds the index of the most recently accepted symbol, so the
    // final symbol is the one accepted while cnt_q == N-2.
    localparam logic [7:0] PENULT_IDX = 8'(N - 2);

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic [7:0]          cnt_d;
    logic [15:0][7:0]    acc_q;
    logic [15:0][7:0]    acc_d;
    logic [127:0]        synd_q;
    logic                synd_valid_q;
`ifdef RS_ERR_FLAG_EN
    logic                err_q;
`endif

    // Multiply by alpha: shift and reduce by p(x) (0x11D).
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1D : 8'h00);
    endfunction

    // Multiply by alpha^p for a constant p (0..15); unrolls to a fixed XOR
    // network per syndrome lane.
    function automatic logic [7:0] mul_alpha_pow(input logic [7:0] a,
                                                 input int unsigned p);
        logic [7:0] r;
        r = a;
        for (int unsigned k = 0; k < 15; k++) begin
            if (k < p) r = xtime(r);
        end
        return r;
    endfunction

    // Horner step for every lane.
    always_comb begin
        acc_d = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            acc_d[i] = mul_alpha_pow(acc_q[i], i) ^ din;
        end
    end

    assign cnt_d = cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            acc_q        <= '0;
            synd_q       <= '0;
            synd_valid_q <= 1'b0;
`ifdef RS_ERR_FLAG_EN
            err_q        <= 1'b0;
`endif
        end else begin
            synd_valid_q <= 1'b0;
            if (din_valid) begin
                if (din_sop) begin
                    // Opens a frame from IDLE, or abandons a partial one.
                    state_q <= ACC;
                    cnt_q   <= '0;
                    acc_q   <= {16{din}};
                end else if (state_q == ACC) begin
                    acc_q <= acc_d;
                    if (cnt_q == PENULT_IDX) begin
                        synd_q       <= acc_d;
                        synd_valid_q <= 1'b1;
                        state_q      <= IDLE;
                        cnt_q        <= '0;
`ifdef RS_ERR_FLAG_EN
                        err_q        <= |acc_d;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                // Non-sop symbols in IDLE are discarded.
            end
        end
    end

    assign synd_valid = synd_valid_q;
    assign synd       = synd_q;
`ifdef RS_ERR_FLAG_EN
    assign err_flag   = err_q;
`endif

endmodule

// File: tb/tb_rs_syndrome.sv
// tb_rs_syndrome -- directed, table-driven bench for rs_syndrome (N = 255).
module tb_rs_syndrome;

    localparam int N = 255;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         din_valid = 1'b0;
    logic         din_sop = 1'b0;
    logic [7:0]   din = 8'h00;
    logic         synd_valid;
    logic [127:0] synd;
`ifdef RS_ERR_FLAG_EN
    logic         err_flag;
`endif

    rs_syndrome #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_sop    (din_sop),
        .din        (din),
        .synd_valid (synd_valid),
        .synd       (synd)
`ifdef RS_ERR_FLAG_EN
        ,
        .err_flag   (err_flag)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    always @(negedge clk) if (synd_valid === 1'b1) pulses++;

    typedef struct {
        int           kind;     // 0: sparse frame (first/last symbol), 1: codeword (first = seed)
        logic [7:0]   first;
        logic [7:0]   last;
        bit           gaps;
        logic [127:0] exp_synd;
    } vec_t;

    vec_t         vt [8];
    logic [7:0]   frame [N];
    logic [7:0]   gpoly [17];
    logic [7:0]   t1 [16] = '{8'h01, 8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36, 8'h1B,
                              8'h83, 8'hCF, 8'hE9, 8'hFA, 8'h7D, 8'hB0, 8'h58, 8'h2C};
    logic [7:0]   t2 [16] = '{8'h02, 8'h01, 8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36,
                              8'h1B, 8'h83, 8'hCF, 8'hE9, 8'hFA, 8'h7D, 8'hB0, 8'h58};
    logic [127:0] tab1, tab2, all5a, held;
    logic [127:0] b2b_exp [3];
    int           p0, cyc, npulse, unstable;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d);
        din_valid = v;
        din_sop   = s;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_sop   = 1'b0;
    endtask

    // g(x) = prod_{i=0..15} (x + alpha^i)
    task automatic build_gpoly();
        logic [7:0] r;
        for (int j = 0; j < 17; j++) gpoly[j] = 8'h00;
        gpoly[0] = 8'h01;
        r = 8'h01;
        for (int i = 0; i < 16; i++) begin
            for (int j = 16; j > 0; j--) gpoly[j] = gpoly[j-1] ^ gmul(gpoly[j], r);
            gpoly[0] = gmul(gpoly[0], r);
            r = gmul(r, 8'h02);
        end
    endtask

    // Sparse frame, or a systematic codeword m(x)x^16 + (m(x)x^16 mod g(x)).
    task automatic build_frame(input int kind, input logic [7:0] a, input logic [7:0] b);
        logic [7:0]  rem [16];
        logic [7:0]  fb;
        logic [31:0] s;
        for (int k = 0; k < N; k++) frame[k] = 8'h00;
        if (kind == 0) begin
            frame[0]   = a;
            frame[N-1] = b;
        end else begin
            for (int j = 0; j < 16; j++) rem[j] = 8'h00;
            s = {24'd0, a} + 32'd7;
            for (int k = 0; k < N - 16; k++) begin
                s = s * 32'd1103515245 + 32'd12345;
                frame[k] = s[23:16];
                fb = frame[k] ^ rem[15];
                for (int j = 15; j > 0; j--) rem[j] = rem[j-1] ^ gmul(fb, gpoly[j]);
                rem[0] = gmul(fb, gpoly[0]);
            end
            for (int j = 0; j < 16; j++) frame[N-16+j] = rem[15-j];
        end
    endtask

    task automatic send_and_check(input string nm, input bit gaps,
                                  input logic [127:0] exp, input int pbase);
        for (int k = 0; k < N; k++) begin
            if (gaps && k > 0 && (k % 7 == 3 || k == N - 1))
                repeat ((k % 3) + 1) drive(1'b0, 1'b0, 8'hC3);
            drive(1'b1, k == 0, frame[k]);
        end
        chk({nm, "_early_pulses"}, 128'(pulses - pbase), 128'd0);
        chk({nm, "_valid"}, {127'd0, synd_valid}, 128'd1);
        chk({nm, "_synd"}, synd, exp);
`ifdef RS_ERR_FLAG_EN
        chk({nm, "_err"}, {127'd0, err_flag}, {127'd0, |exp});
`endif
        drive(1'b0, 1'b0, 8'h00);
        chk({nm, "_pulse_end"}, {127'd0, synd_valid}, 128'd0);
        chk({nm, "_synd_hold"}, synd, exp);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tab1[8*i +: 8] = t1[i];
            tab2[8*i +: 8] = t2[i];
        end
        all5a = {16{8'h5A}};
        vt[0] = '{0, 8'h00, 8'h00, 1'b0, 128'd0};
        vt[1] = '{0, 8'h01, 8'h00, 1'b0, tab1};
        vt[2] = '{0, 8'h00, 8'h5A, 1'b0, all5a};
        vt[3] = '{0, 8'h01, 8'h5A, 1'b0, tab1 ^ all5a};
        vt[4] = '{0, 8'h02, 8'h00, 1'b0, tab2};
        vt[5] = '{0, 8'h01, 8'h00, 1'b1, tab1};
        vt[6] = '{1, 8'h03, 8'h00, 1'b0, 128'd0};
        vt[7] = '{1, 8'h09, 8'h00, 1'b1, 128'd0};
        build_gpoly();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {127'd0, synd_valid}, 128'd0);
        chk("rst_synd", synd, 128'd0);
`ifdef RS_ERR_FLAG_EN
        chk("rst_err", {127'd0, err_flag}, 128'd0);
`endif
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single frames
        for (int v = 0; v < 8; v++) begin
            build_frame(vt[v].kind, vt[v].first, vt[v].last);
            send_and_check($sformatf("vec%0d", v), vt[v].gaps, vt[v].exp_synd, pulses);
        end

        // Back-to-back frames: codeword, sparse 0x01, codeword
        b2b_exp[0] = 128'd0;
        b2b_exp[1] = tab1;
        b2b_exp[2] = 128'd0;
        cyc = 0;
        npulse = 0;
        unstable = 0;
        held = synd;
        for (int f = 0; f < 3; f++) begin
            if (f == 1) build_frame(0, 8'h01, 8'h00);
            else        build_frame(1, 8'(17 + f), 8'h00);
            for (int k = 0; k < N; k++) begin
                drive(1'b1, k == 0, frame[k]);
                cyc++;
                if (synd_valid === 1'b1) begin
                    npulse++;
                    chk($sformatf("b2b_time%0d", npulse), 128'(cyc), 128'(N * npulse));
                    if (npulse <= 3)
                        chk($sformatf("b2b_synd%0d", npulse), synd, b2b_exp[npulse-1]);
                    held = synd;
                end else if (npulse > 0 && synd !== held) begin
                    unstable++;
                end
            end
        end
        chk("b2b_npulse", 128'(npulse), 128'd3);
        chk("b2b_stable", 128'(unstable), 128'd0);
        drive(1'b0, 1'b0, 8'h00);
        chk("b2b_pulse_end", {127'd0, synd_valid}, 128'd0);

        // Reset at symbol 100, stray non-sop symbols, then a full frame
        p0 = pulses;
        build_frame(0, 8'h01, 8'h00);
        for (int k = 0; k < 100; k++) drive(1'b1, k == 0, frame[k]);
        #2 rst = 1'b0;
        #1;
        chk("midrst_valid", {127'd0, synd_valid}, 128'd0);
        chk("midrst_synd", synd, 128'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 8'h77);
        build_frame(0, 8'h02, 8'h00);
        send_and_check("midrst", 1'b0, tab2, p0);

        // sop at symbol 50 of an open frame abandons it
        p0 = pulses;
        build_frame(0, 8'h01, 8'h33);
        for (int k = 0; k < 50; k++) drive(1'b1, k == 0, frame[k]);
        build_frame(0, 8'h00, 8'h5A);
        send_and_check("restart", 1'b0, all5a, p0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_syndrome.md
RS_SYNDROME -- requirements
Module: rs_syndrome

Interface
REQ-001 SHALL have parameter N, 255, codeword length in symbols (legal 17..255, shortened codes allowed).
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port din_valid  input  1  din carries a received symbol this cycle.
REQ-005 SHALL have port din_sop  input  1  qualifies the first symbol of a codeword; ignored when din_valid=0.
REQ-006 SHALL have port din  input  8  received symbol, highest-degree coefficient first (message symbols, then 16 parity).
REQ-007 SHALL have port synd_valid  output  1  one-cycle pulse; synd holds a complete result.
REQ-008 SHALL have port synd  output  128  S0 in [7:0] through S15 in [127:120].
REQ-009 SHALL have port err_flag  output  1  present only with RS_ERR_FLAG_EN.

Function
REQ-010 SHALL compute S_i = r(alpha^i), i=0..15, over GF(2^8) with p(x)=x^8+x^4+x^3+x^2+1, alpha=0x02, first consecutive root alpha^0.
REQ-011 SHALL evaluate by Horner, one symbol per accepted cycle: on sop, acc_i <= din; otherwise acc_i <= (acc_i * alpha^i) ^ din, using constant XOR-network multipliers.
REQ-012 SHALL use a symbol counter 0..N-1; states IDLE (no frame open) and ACC (frame open).
REQ-013 IDLE -> ACC on din_valid & din_sop; symbols with din_valid & !din_sop in IDLE are discarded.
REQ-014 ACC: din_valid=0 SHALL hold accumulators and counter (gaps of any length allowed).
REQ-015 On acceptance of symbol N-1, the final accumulators SHALL be copied to the synd register and synd_valid SHALL assert the next cycle, for exactly one cycle (latency 1 clock after last symbol edge).
REQ-016 After symbol N-1 the block SHALL return to IDLE, unless din_sop is accepted on the following cycle, in which case a new frame opens with no bubble (back-to-back, 1 symbol/clock sustained).
REQ-017 synd SHALL remain stable from its synd_valid pulse until the next synd_valid pulse, independent of accumulation of the next frame.
REQ-018 din_valid & din_sop during ACC SHALL abandon the partial frame (no synd_valid for it) and restart with the new symbol at count 0.
REQ-019 Counter SHALL never exceed N-1; no wrap within a frame.

Reset
REQ-020 rst=0 SHALL asynchronously clear accumulators, counter, synd (all 0), synd_valid=0, err_flag=0, state IDLE.
REQ-021 Reset mid-frame SHALL discard the partial frame; no synd_valid until a full new frame after sop.
REQ-022 First accepted symbol after reset release SHALL require din_sop.

Configuration
REQ-023 Macro RS_ERR_FLAG_EN defined: err_flag SHALL be a registered output, updated in the same cycle as synd, =1 iff any S_i != 0, held like synd.
REQ-024 Macro RS_ERR_FLAG_EN undefined: err_flag port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-025 N=255, all-zero codeword, contiguous -> one synd_valid pulse, synd=0, err_flag=0.
REQ-026 N=255, first symbol 0x01, rest 0x00 -> S0=0x01, S1=0x8E (alpha^254), err_flag=1.
REQ-027 N=255, only last symbol 0x5A, rest 0 -> every S_i=0x5A.
REQ-028 Two valid codewords (encoder output) back-to-back, second sop on cycle after first's last symbol -> two pulses 255 cycles apart, both synd=0, first synd stable until second pulse.
REQ-029 Random din_valid gaps inside a frame -> result identical to contiguous run of same symbols.
REQ-030 rst asserted at symbol 100, then sop restart; separately, sop at symbol 50 of an open frame -> no pulse for abandoned frames; correct result for the restarted frame only.
